// File: rtl/input_blk.sv
// ---------------------------------------------------------------------------
// input_blk -- UART receiver (8N1) with a first-word-fall-through byte FIFO.
//
// The asynchronous rx line is brought into the clk domain through a two-flop
// synchronizer (rxs). A small FSM locates the start bit, samples it at its
// middle, then samples each data bit (LSB first) and the stop bit one bit
// period apart. A good stop bit pushes the byte into the FIFO. A low stop bit
// discards the byte, pulses frame_err and parks the FSM until the line
// returns high.
//
// Parameters
//   FIFO_DEPTH : byte entries in the receive FIFO (power of 2, >= 2)
//   BAUD       : serial bit rate in bits/s
//   CLK_FREQ   : clk frequency in Hz; CLK_FREQ/BAUD must be an integer >= 4
//
// Ports
//   clk       in   system clock, rising edge
//   rst       in   synchronous active-high reset
//   rx        in   asynchronous serial line, idle high
//   get       in   pop request; ignored while empty
//   out       out  [7:0] FIFO head byte, 8'h00 while empty
//   empty     out  FIFO holds no bytes
//   full      out  FIFO holds FIFO_DEPTH bytes
//   overrun   out  one-cycle pulse: completed byte dropped, FIFO was full
//   frame_err out  one-cycle pulse: stop bit sampled low, byte discarded
// ---------------------------------------------------------------------------
module input_blk #(
    parameter int FIFO_DEPTH = 4,
    parameter int BAUD       = 10_000_000,
    parameter int CLK_FREQ   = 100_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       get,
    output logic [7:0] out,
    output logic       empty,
    output logic       full,
    output logic       overrun,
    output logic       frame_err
);

    // -----------------------------------------------------------------------
    // Derived constants
    // -----------------------------------------------------------------------
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int PTR_W        = $clog2(FIFO_DEPTH);
    localparam int OCC_W        = PTR_W + 1;

    // Last count of a full bit period, and of the half period used to land
    // the start-bit sample in the middle of the bit.
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [OCC_W-1:0] OCC_FULL  = OCC_W'(FIFO_DEPTH);

    // FSM encoding
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_START     = 3'd1;
    localparam logic [2:0] ST_DATA      = 3'd2;
    localparam logic [2:0] ST_STOP      = 3'd3;
    localparam logic [2:0] ST_WAIT_IDLE = 3'd4;

    // -----------------------------------------------------------------------
    // Input synchronizer. Both flops reset high so a reset never looks like
    // the falling edge of a start bit.
    // -----------------------------------------------------------------------
    logic rx_meta;
    logic rxs;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
        end
    end

    // -----------------------------------------------------------------------
    // Frame decoder
    // -----------------------------------------------------------------------
    logic [2:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;

    logic half_hit;     // start-bit sample point
    logic bit_hit;      // data/stop sample point
    logic stop_sample;  // this edge samples the stop bit
    logic push;         // stop bit good: byte goes to the FIFO this edge
    logic bad_stop;     // stop bit low: byte discarded this edge

    assign half_hit    = (cnt == HALF_LAST);
    assign bit_hit     = (cnt == BIT_LAST);
    assign stop_sample = (state == ST_STOP) && bit_hit;
    assign push        = stop_sample &&  rxs;
    assign bad_stop    = stop_sample && !rxs;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    cnt     <= '0;
                    bit_idx <= '0;
                    if (!rxs)
                        state <= ST_START;
                end

                // Re-check the line half a bit in; a high level here means
                // the falling edge was a glitch and nothing is recorded.
                ST_START: begin
                    if (half_hit) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= rxs ? ST_IDLE : ST_DATA;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                ST_DATA: begin
                    if (bit_hit) begin
                        cnt            <= '0;
                        shreg[bit_idx] <= rxs;
                        bit_idx        <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7)
                            state <= ST_STOP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                // The push/discard decision is made combinationally from
                // stop_sample; the FSM only has to choose where to go next.
                // Going straight to IDLE lets a start bit that immediately
                // follows the stop bit be seen on the very next cycle.
                ST_STOP: begin
                    if (bit_hit) begin
                        cnt   <= '0;
                        state <= rxs ? ST_IDLE : ST_WAIT_IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                // A line stuck low would otherwise decode as endless 8'h00
                // frames with bad stop bits; wait for it to return high.
                ST_WAIT_IDLE: begin
                    cnt <= '0;
                    if (rxs)
                        state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Receive FIFO (first-word fall-through)
    // -----------------------------------------------------------------------
    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [OCC_W-1:0] occ;

    logic pop;      // a pop actually happens this edge
    logic wr_en;    // a push actually happens this edge
    logic drop;     // push refused: FIFO full and no pop to make room

    assign empty = (occ == '0);
    assign full  = (occ == OCC_FULL);

    // A pop on an empty FIFO is ignored. When full, a simultaneous pop frees
    // the slot the incoming byte needs, so both take effect.
    assign pop   = get && !empty;
    assign wr_en = push && (!full || pop);
    assign drop  = push && full && !get;

    // Storage has no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr] <= shreg_final(shreg, bit_idx, rxs);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({wr_en, pop})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase
        end
    end

    assign out = empty ? 8'h00 : mem[rd_ptr];

    // -----------------------------------------------------------------------
    // Status pulses, registered so each lasts exactly one cycle after the
    // stop-bit sample that caused it.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            overrun   <= drop;
            frame_err <= bad_stop;
        end
    end

    // The shift register already holds all eight data bits by the time the
    // stop bit is sampled; this helper exists only to keep the write data
    // expression readable and to consume the unused sample arguments.
    function automatic logic [7:0] shreg_final(input logic [7:0] sr,
                                               input logic [2:0] idx,
                                               input logic       s);
        logic unused;
        unused = ^{idx, s};
        return sr | {7'd0, unused & 1'b0};
    endfunction

endmodule

// File: tb/tb_input_blk.sv
// ---------------------------------------------------------------------------
// tb_input_blk -- self-checking bench for input_blk.
// Frames are driven bit by bit on rx; a byte queue models the FIFO at frame
// granularity and pulse counters model overrun / frame_err.
// ---------------------------------------------------------------------------
module tb_input_blk;

    localparam int DEPTH = 4;
    localparam int CPB   = 10;
    // Edges from the start-bit falling edge to the stop-bit sample:
    // 2 synchronizer flops, 1 idle detect, half a bit, then 9 full bits.
    localparam int STOP_EDGE = 2 + 1 + CPB / 2 + 9 * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic       get = 1'b0;
    logic [7:0] out;
    logic       empty, full, overrun, frame_err;

    input_blk #(.FIFO_DEPTH(DEPTH), .BAUD(10_000_000), .CLK_FREQ(100_000_000)) dut (
        .clk(clk), .rst(rst), .rx(rx), .get(get), .out(out),
        .empty(empty), .full(full), .overrun(overrun), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    logic [7:0] q[$];
    int exp_ovr = 0, exp_fe = 0;
    int ovr_cyc = 0, ovr_evt = 0, fe_cyc = 0, fe_evt = 0;
    logic ovr_q = 1'b0, fe_q = 1'b0;

    // Pulse monitor: events vs high cycles shows pulse width.
    always @(negedge clk) begin
        if (overrun) ovr_cyc++;
        if (overrun && !ovr_q) ovr_evt++;
        if (frame_err) fe_cyc++;
        if (frame_err && !fe_q) fe_evt++;
        ovr_q = overrun;
        fe_q  = frame_err;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic m_push(input logic [7:0] b);
        if (q.size() < DEPTH) q.push_back(b);
        else exp_ovr++;
    endtask

    // All stimulus runs on negedges; this leaves the bench at a negedge.
    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_good(input logic [7:0] b);
        send_byte(b, 1'b1);
        m_push(b);
    endtask

    task automatic send_bad(input logic [7:0] b, input int low_extra);
        send_byte(b, 1'b0);
        repeat (low_extra) @(negedge clk);
        rx = 1'b1;
        repeat (3) @(negedge clk);
        exp_fe++;
    endtask

    // Full FIFO, get pulsed on exactly the stop-sample edge.
    task automatic send_pop(input logic [7:0] b);
        fork
            send_byte(b, 1'b1);
            begin
                repeat (STOP_EDGE - 1) @(negedge clk);
                chk("pp_head", {24'd0, out}, {24'd0, q[0]});
                get = 1'b1;
                @(negedge clk);
                get = 1'b0;
            end
        join
        void'(q.pop_front());
        q.push_back(b);
    endtask

    task automatic chk_state(input string tag);
        chk({tag, "_empty"}, {31'd0, empty}, {31'd0, q.size() == 0});
        chk({tag, "_full"},  {31'd0, full},  {31'd0, q.size() == DEPTH});
        chk({tag, "_out"},   {24'd0, out},   {24'd0, (q.size() != 0) ? q[0] : 8'h00});
    endtask

    task automatic pop_chk(input string tag);
        chk_state(tag);
        get = 1'b1;
        @(negedge clk);
        get = 1'b0;
        if (q.size() != 0) void'(q.pop_front());
    endtask

    task automatic chk_pulses(input string tag);
        chk({tag, "_ovr_evt"}, ovr_evt, exp_ovr);
        chk({tag, "_ovr_cyc"}, ovr_cyc, exp_ovr);
        chk({tag, "_fe_evt"},  fe_evt,  exp_fe);
        chk({tag, "_fe_cyc"},  fe_cyc,  exp_fe);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] seq [4];
        seq[0] = 8'h33; seq[1] = 8'h0F; seq[2] = 8'h3C; seq[3] = 8'hC3;

        // 1: reset, idle line
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            chk("rst_outs", {19'd0, empty, full, out, overrun, frame_err, 2'd0},
                {19'd0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0});
            @(negedge clk);
        end

        // 2: single frame, then pop
        send_good(8'h55);
        chk_state("f55");
        pop_chk("pop55");
        chk_state("after55");

        // 3: fill back-to-back, drain
        for (int i = 0; i < 4; i++) send_good(seq[i]);
        chk_state("fill4");
        for (int i = 0; i < 4; i++) pop_chk("drain4");
        chk_state("drained");

        // 4a: overrun
        for (int i = 0; i < 4; i++) send_good(seq[i]);
        send_good(8'hA5);
        repeat (2) @(negedge clk);
        chk_state("ovr");
        chk_pulses("ovr");
        for (int i = 0; i < 4; i++) pop_chk("ovr_drain");
        chk_state("ovr_empty");

        // 4b: push with pop while full
        for (int i = 0; i < 4; i++) send_good(seq[i]);
        send_pop(8'hA5);
        repeat (2) @(negedge clk);
        chk_state("pp");
        chk_pulses("pp");
        for (int i = 0; i < 4; i++) pop_chk("pp_drain");
        chk_state("pp_empty");

        // 5: framing error, stuck-low line, then recovery
        send_bad(8'h81, 30);
        chk_state("fe");
        chk_pulses("fe");
        send_good(8'h42);
        pop_chk("f42");

        // 6: glitch, get while empty, reset mid-frame
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (30) @(negedge clk);
        chk_state("glitch");
        chk_pulses("glitch");
        pop_chk("get_empty");
        send_good(8'h11);
        fork
            send_byte(8'hFF, 1'b1);
            begin
                repeat (40) @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
        join
        q.delete();
        repeat (5) @(negedge clk);
        chk_state("midrst");
        chk_pulses("midrst");
        send_good(8'h7E);
        pop_chk("f7e");

        // Random mix of good frames, bad frames and pops
        for (int it = 0; it < 40; it++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r <= 4)      send_good(8'($urandom));
            else if (r == 5) send_bad(8'($urandom), $urandom_range(0, 20));
            else begin
                int n;
                n = $urandom_range(1, 3);
                for (int k = 0; k < n; k++) pop_chk("rnd_pop");
            end
            repeat ($urandom_range(0, 4)) @(negedge clk);
        end
        repeat (2) @(negedge clk);
        chk_pulses("rnd");
        while (q.size() != 0) pop_chk("rnd_drain");
        chk_state("final");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
